lobster_fetch: RTL and testbench
================================

// Module: lobster_fetch
// PURPOSE
//   Instruction fetch stage feeding the lobster execution engine. Issues 64-bit
//   fetch requests to the SRAM port, buffers the returned words with their PCs in
//   a small prefetch FIFO, and hands them to the executor over a valid/ready handshake.
//   A redirect (branch/task switch) flushes the buffer and restarts fetch at a new PC.
// PARAMETERS
//   ADDR_WIDTH  36        SRAM byte-address width
//   FIFO_DEPTH  4         prefetch entries; power of two, >= 2
//   RESET_PC    'hF800    first fetch address after reset
// PORTS
//   clk          in   1           clock, all state on rising edge
//   rst          in   1           reset, asynchronous, active-high
//   mem_ce       out  1           fetch request; held until mem_rdy
//   mem_addr     out  ADDR_WIDTH  fetch address, 8-byte aligned, stable while mem_ce=1
//   mem_rdy      in   1           SRAM: mem_data valid for current request this cycle
//   mem_data     in   64          SRAM read data
//   redirect     in   1           flush and restart fetch at redirect_pc
//   redirect_pc  in   ADDR_WIDTH  new fetch PC; bits [2:0] ignored (treated as 0)
//   inst_valid   out  1           FIFO head valid
//   inst_data    out  64          instruction word at head
//   inst_pc      out  ADDR_WIDTH  address of inst_data
//   inst_ready   in   1           executor accepts head this cycle
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, mem_ce=0, mem_addr=RESET_PC, fetch_pc=RESET_PC,
//   FIFO empty, inst_valid=0, inst_data=0, inst_pc=0. Reset mid-request abandons it.
// - FSM: IDLE (mem_ce=0), WAIT (mem_ce=1, mem_addr=fetch_pc), DROP (mem_ce=1, old addr,
//   response discarded).
// - Credit: room = (occupancy after this cycle's pop) < FIFO_DEPTH; at most one outstanding.
// - IDLE -> WAIT when room and no redirect. First edge after rst release: WAIT, addr=RESET_PC.
// - WAIT & mem_rdy & !redirect: push {mem_data, fetch_pc}; fetch_pc += 8 (wraps mod
//   2^ADDR_WIDTH); stay WAIT if room remains after push, else IDLE.
// - WAIT & !mem_rdy & redirect: -> DROP; fetch_pc = redirect_pc & ~7.
// - WAIT & mem_rdy & redirect: data discarded; fetch_pc = redirect_pc & ~7; -> WAIT.
// - DROP: keep old address until mem_rdy; discard data; -> WAIT at fetch_pc.
//   Redirect in DROP only updates fetch_pc.
// - IDLE & redirect: fetch_pc updated, -> WAIT.
// - Zero-wait SRAM: mem_ce/mem_rdy in cycle N -> inst_valid at cycle N+1.
//   Sustains one word/cycle with inst_ready=1.
// - FIFO: pop when inst_valid & inst_ready; simultaneous push+pop keeps occupancy;
//   never overflows (credit rule). Head outputs driven from registers.
// - Redirect has priority: FIFO cleared same edge, pop/push that cycle ignored,
//   inst_valid=0 next cycle.
// - Fetched data is not decoded or altered here.
// TESTING
// 1 rst 1->0, mem_rdy=1, inst_ready=1 -> mem_addr F800,F808,F810 on successive cycles;
//   inst_pc same sequence one cycle later.
// 2 inst_ready=0, mem_rdy=1 -> exactly 4 pushes (F800..F818), then mem_ce=0;
//   inst_ready=1 for one cycle -> one pop, fetch resumes at F820.
// 3 mem_rdy held 0 three cycles then 1 -> mem_addr stable F800 throughout;
//   one push, inst_pc=F800.
// 4 redirect=1, redirect_pc='h1234 while WAIT with mem_rdy=0 -> DROP; old word discarded
//   on mem_rdy; next request addr='h1230; FIFO empty in between.
// 5 redirect and mem_rdy same cycle -> word not pushed, next cycle mem_addr=redirect target,
//   inst_valid=0.
// 6 rst asserted mid-WAIT -> mem_ce=0, inst_valid=0 without clock edge;
//   after release fetch restarts at F800.
// 7 fetch_pc at 2^36-8, streaming -> next mem_addr wraps to 0.

Source files
------------

// File: rtl/lobster_fetch.sv
// lobster_fetch: instruction fetch stage with a prefetch FIFO, one outstanding
// SRAM request and redirect flush.
module lobster_fetch #(
  parameter int ADDR_WIDTH = 36,
  parameter int FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'hF800
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_ce,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rdy,
  input  logic [63:0]           mem_data,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  output logic [63:0]           inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
  state_t                r_state;
  logic                  r_ce;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_fetch_pc;
  logic [63:0]           r_data [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc [FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_cnt;
  logic                  w_pop;
  logic                  w_push;
  logic [PW:0]           w_occ;
  logic                  w_room;
  logic                  w_room_push;
  logic [ADDR_WIDTH-1:0] w_rpc;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  assign inst_valid  = r_cnt != '0;
  assign inst_data   = r_data[r_rptr];
  assign inst_pc     = r_pc[r_rptr];
  assign mem_ce      = r_ce;
  assign mem_addr    = r_addr;
  assign w_pop       = inst_valid & inst_ready & ~redirect;
  assign w_push      = (r_state == WAIT) & mem_rdy & ~redirect;
  assign w_occ       = r_cnt - (PW+1)'(w_pop);
  assign w_room      = w_occ < DEPTH_C;
  assign w_room_push = (w_occ + (PW+1)'(1)) < DEPTH_C;
  assign w_rpc       = {redirect_pc[ADDR_WIDTH-1:3], 3'b000};
  assign w_next_pc   = r_fetch_pc + ADDR_WIDTH'(8);
  // Credit is granted before issuing, so every accepted response has a free slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ce       <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect) begin
            r_fetch_pc <= w_rpc;
            r_addr     <= w_rpc;
            r_ce       <= 1'b1;
            r_state    <= WAIT;
          end else if (w_room) begin
            r_addr  <= r_fetch_pc;
            r_ce    <= 1'b1;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            r_fetch_pc <= w_rpc;
            if (mem_rdy) r_addr <= w_rpc;
            r_state <= mem_rdy ? WAIT : DROP;
          end else if (mem_rdy) begin
            r_fetch_pc <= w_next_pc;
            r_addr     <= w_next_pc;
            r_ce       <= w_room_push;
            r_state    <= w_room_push ? WAIT : IDLE;
          end
        end
        DROP: begin
          if (redirect) r_fetch_pc <= w_rpc;
          if (mem_rdy) begin
            r_addr  <= redirect ? w_rpc : r_fetch_pc;
            r_state <= WAIT;
          end
        end
        default: begin
          r_ce    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_data[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (redirect) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_data[r_wptr] <= mem_data;
        r_pc[r_wptr]   <= r_fetch_pc;
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_lobster_fetch.sv
// tb_lobster_fetch: directed scenarios with a scoreboard of expected {data, pc}
// entries pushed on each accepted fetch and popped on each executor handshake.
module tb_lobster_fetch;
  localparam logic [35:0] RST_PC = 36'hF800;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ce;
  logic [35:0] mem_addr;
  logic        mem_rdy;
  logic [63:0] mem_data;
  logic        redirect;
  logic [35:0] redirect_pc;
  logic        inst_valid;
  logic [63:0] inst_data;
  logic [35:0] inst_pc;
  logic        inst_ready;
  int          checks = 0;
  int          errors = 0;
  logic [99:0] q[$];
  logic [35:0] exp_pc;
  logic [35:0] drop_addr;
  logic        drop_pend;

  lobster_fetch dut (
    .clk(clk), .rst(rst), .mem_ce(mem_ce), .mem_addr(mem_addr), .mem_rdy(mem_rdy),
    .mem_data(mem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;
  assign mem_data = {28'hC0FFEE1, mem_addr};

  function automatic logic [99:0] entry(logic [35:0] pc);
    return {28'hC0FFEE1, pc, pc};
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_pc    = RST_PC;
    drop_pend = 1'b0;
    drop_addr = '0;
  endtask

  // Evaluates the handshakes of the current cycle, then advances one clock.
  task automatic clock();
    if (mem_ce) chk("mem_addr", mem_addr, drop_pend ? drop_addr : exp_pc);
    if (redirect) begin
      if (mem_ce && !mem_rdy && !drop_pend) begin
        drop_pend = 1'b1;
        drop_addr = exp_pc;
      end else if (mem_ce && mem_rdy && drop_pend) drop_pend = 1'b0;
      exp_pc = {redirect_pc[35:3], 3'b000};
      q.delete();
    end else begin
      if (inst_valid && inst_ready) begin
        if (q.size() > 0) chk("pop", {inst_data, inst_pc}, q.pop_front());
        else chk("pop_unexpected", inst_valid, 1'b0);
      end
      if (mem_ce && mem_rdy) begin
        if (drop_pend) drop_pend = 1'b0;
        else begin
          q.push_back(entry(exp_pc));
          exp_pc = exp_pc + 36'd8;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; mem_rdy = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    model_reset();
    #12;
    chk("rst_ce", mem_ce, 1'b0);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_data", inst_data, 64'h0);
    chk("rst_pc", inst_pc, 36'h0);
    chk("rst_addr", mem_addr, RST_PC);
    // streaming with zero-wait SRAM
    rst = 1'b0; mem_rdy = 1'b1; inst_ready = 1'b1;
    clock();
    chk("t1_ce", mem_ce, 1'b1);
    chk("t1_addr0", mem_addr, 36'hF800);
    chk("t1_valid0", inst_valid, 1'b0);
    clock();
    chk("t1_addr1", mem_addr, 36'hF808);
    chk("t1_pc0", inst_pc, 36'hF800);
    clock();
    chk("t1_addr2", mem_addr, 36'hF810);
    chk("t1_pc1", inst_pc, 36'hF808);
    clock();
    chk("t1_pc2", inst_pc, 36'hF810);
    // fill the FIFO with the executor stalled
    inst_ready = 1'b0;
    do_reset();
    repeat (4) clock();
    chk("t2_ce_before_full", mem_ce, 1'b1);
    clock();
    chk("t2_ce_full", mem_ce, 1'b0);
    chk("t2_head", inst_pc, 36'hF800);
    clock();
    chk("t2_ce_still_idle", mem_ce, 1'b0);
    inst_ready = 1'b1;
    clock();
    inst_ready = 1'b0;
    chk("t2_resume_ce", mem_ce, 1'b1);
    chk("t2_resume_addr", mem_addr, 36'hF820);
    chk("t2_head_after_pop", inst_pc, 36'hF808);
    clock();
    chk("t2_refull_ce", mem_ce, 1'b0);
    // SRAM wait states
    mem_rdy = 1'b0; inst_ready = 1'b1;
    do_reset();
    repeat (4) clock();
    chk("t3_addr_stable", mem_addr, 36'hF800);
    chk("t3_valid_none", inst_valid, 1'b0);
    mem_rdy = 1'b1;
    clock();
    mem_rdy = 1'b0;
    chk("t3_valid", inst_valid, 1'b1);
    chk("t3_pc", inst_pc, 36'hF800);
    clock();
    chk("t3_drained", inst_valid, 1'b0);
    // redirect while a request is pending
    redirect = 1'b1; redirect_pc = 36'h1234;
    clock();
    redirect = 1'b0;
    chk("t4_drop_addr", mem_addr, 36'hF808);
    chk("t4_drop_ce", mem_ce, 1'b1);
    clock();
    chk("t4_empty", inst_valid, 1'b0);
    mem_rdy = 1'b1;
    clock();
    chk("t4_new_addr", mem_addr, 36'h1230);
    chk("t4_discarded", inst_valid, 1'b0);
    clock();
    chk("t4_pc", inst_pc, 36'h1230);
    // redirect coinciding with a returned word
    redirect = 1'b1; redirect_pc = 36'h5_6789_ABCF;
    clock();
    redirect = 1'b0;
    chk("t5_addr", mem_addr, 36'h5_6789_ABC8);
    chk("t5_valid", inst_valid, 1'b0);
    clock();
    chk("t5_pc", inst_pc, 36'h5_6789_ABC8);
    // asynchronous reset in the middle of a request
    mem_rdy = 1'b0;
    clock();
    rst = 1'b1;
    #1;
    chk("t6_ce", mem_ce, 1'b0);
    chk("t6_valid", inst_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mem_rdy = 1'b1;
    clock();
    chk("t6_restart", mem_addr, 36'hF800);
    clock();
    chk("t6_pc", inst_pc, 36'hF800);
    // address wrap at the top of the space
    redirect = 1'b1; redirect_pc = 36'hF_FFFF_FFF8;
    clock();
    redirect = 1'b0;
    chk("t7_top", mem_addr, 36'hF_FFFF_FFF8);
    clock();
    chk("t7_wrap", mem_addr, 36'h0);
    chk("t7_top_pc", inst_pc, 36'hF_FFFF_FFF8);
    clock();
    chk("t7_zero_pc", inst_pc, 36'h0);
    mem_rdy = 1'b0;
    repeat (3) clock();
    chk("end_empty", inst_valid, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
